// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults, address type and helpers for the
//                scoreboarded integer register file.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int ZERO_IDX      = 0;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    // Register address type for the default configuration.
    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    // Width needed to hold a count of 0..nregs pending registers.
    function automatic int busy_count_width(input int nregs);
        return $clog2(nregs + 1);
    endfunction

    // An address refers to real, writable storage only when it is inside the
    // file and is not the hardwired zero register.
    function automatic logic addr_usable(input int addr, input int nregs, input int zero_reg);
        return (addr < nregs) && !((zero_reg != 0) && (addr == ZERO_IDX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational read port: address mux, zero/out-of-range
//                masking and write-to-read bypass.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int AW       = $clog2(NREGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [NREGS*XLEN-1:0] regs,
    input  logic [NREGS-1:0]      pending,
    input  logic [AW-1:0]         addr,
    input  logic                  write_ok,
    input  logic [AW-1:0]         write_addr,
    input  logic [XLEN-1:0]       write_data,
    output logic [XLEN-1:0]       data,
    output logic                  busy
);

    logic          usable;
    logic          hit;
    logic [AW-1:0] idx;

    // Select register contents, masking unusable addresses and forwarding a
    // same-cycle legal write when bypass is enabled.
    always_comb begin
        usable = addr_usable(int'(addr), NREGS, ZERO_REG);
        idx    = usable ? addr : '0;
        hit    = (BYPASS != 0) && write_ok && (write_addr == addr);
        if (!usable) begin
            data = '0;
        end else if (hit) begin
            data = write_data;
        end else begin
            data = regs[idx*XLEN +: XLEN];
        end
        busy = usable && !hit && pending[idx];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Parametrised integer register file with per-register pending
//                bits for RAW/WAW hazard tracking and a pending-register count.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NREAD    = 2,
    parameter int AW       = $clog2(NREGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREAD*AW-1:0]          readAddr,
    output logic [NREAD*XLEN-1:0]        readData,
    output logic [NREAD-1:0]             readBusy,
    input  logic                         regWrite,
    input  logic [AW-1:0]                writeAddr,
    input  logic [XLEN-1:0]              writeData,
    input  logic                         issueValid,
    input  logic [AW-1:0]                issueAddr,
    output logic                         issueReady,
    input  logic                         flush,
    output logic [$clog2(NREGS+1)-1:0]   busyCount
);

    localparam int CW = busy_count_width(NREGS);

    logic [NREGS*XLEN-1:0] regs;
    logic [NREGS-1:0]      pending;
    logic                  write_ok;
    logic                  issue_addr_ok;
    logic                  bypass_issue;
    logic                  issue_fire;
    logic                  count_set;
    logic                  count_clr;
    logic [AW-1:0]         write_idx;
    logic [AW-1:0]         issue_idx;

    // Decode write legality, issue readiness and the exact pending transitions
    // that the count must follow; writes are suppressed while in reset.
    always_comb begin
        write_ok      = rst_n && regWrite && addr_usable(int'(writeAddr), NREGS, ZERO_REG);
        issue_addr_ok = addr_usable(int'(issueAddr), NREGS, ZERO_REG);
        write_idx     = write_ok ? writeAddr : '0;
        issue_idx     = issue_addr_ok ? issueAddr : '0;
        bypass_issue  = (BYPASS != 0) && write_ok && (writeAddr == issueAddr);
        issueReady    = !issue_addr_ok || !pending[issue_idx] || bypass_issue;
        issue_fire    = issueValid && issueReady && !flush && issue_addr_ok;
        // A same-register write+issue leaves the bit set: no transition at all
        // when it was already pending, a plain set when it was clear.
        count_set     = issue_fire && !pending[issue_idx];
        count_clr     = write_ok && pending[write_idx] &&
                        !(issue_fire && (issueAddr == writeAddr));
    end

    // Register storage: writeback updates one register per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (write_ok) begin
            regs[write_idx*XLEN +: XLEN] <= writeData;
        end
    end

    // Pending bits and their population count; issue after write so the new
    // producer wins, flush squashes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            busyCount <= '0;
        end else if (flush) begin
            pending   <= '0;
            busyCount <= '0;
        end else begin
            if (write_ok) begin
                pending[write_idx] <= 1'b0;
            end
            if (issue_fire) begin
                pending[issue_idx] <= 1'b1;
            end
            busyCount <= busyCount + CW'(count_set) - CW'(count_clr);
        end
    end

    generate
        for (genvar i = 0; i < NREAD; i++) begin : g_read
            regfile_read_port #(
                .XLEN     (XLEN),
                .NREGS    (NREGS),
                .AW       (AW),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .regs       (regs),
                .pending    (pending),
                .addr       (readAddr[i*AW +: AW]),
                .write_ok   (write_ok),
                .write_addr (writeAddr),
                .write_data (writeData),
                .data       (readData[i*XLEN +: XLEN]),
                .busy       (readBusy[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Scoreboard bench for two register-file configurations:
//                A = 24 regs, 3 ports, bypass, zero reg;
//                B = 32 regs, 2 ports, no bypass, no zero reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    typedef struct packed {
        logic [2:0][31:0] rd_a;
        logic [2:0]       bz_a;
        logic             rdy_a;
        logic [7:0]       cnt_a;
        logic [1:0][31:0] rd_b;
        logic [1:0]       bz_b;
        logic             rdy_b;
        logic [7:0]       cnt_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        issueValid;
    logic [4:0]  issueAddr;
    logic        flush;

    logic [14:0] raddr_a;
    logic [95:0] rdata_a;
    logic [2:0]  rbusy_a;
    logic        ready_a;
    logic [4:0]  cnt_a;

    logic [9:0]  raddr_b;
    logic [63:0] rdata_b;
    logic [1:0]  rbusy_b;
    logic        ready_b;
    logic [5:0]  cnt_b;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] m_reg  [2][32];
    bit          m_pend [2][32];

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .XLEN(32), .NREGS(24), .NREAD(3), .BYPASS(1), .ZERO_REG(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .readAddr(raddr_a), .readData(rdata_a), .readBusy(rbusy_a),
        .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
        .issueValid(issueValid), .issueAddr(issueAddr), .issueReady(ready_a),
        .flush(flush), .busyCount(cnt_a)
    );

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .readAddr(raddr_b), .readData(rdata_b), .readBusy(rbusy_b),
        .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
        .issueValid(issueValid), .issueAddr(issueAddr), .issueReady(ready_b),
        .flush(flush), .busyCount(cnt_b)
    );

    // ---------------- reference model ----------------
    function automatic int nregs_of(input int c);
        return (c == 0) ? 24 : 32;
    endfunction

    function automatic bit byp_of(input int c);
        return (c == 0);
    endfunction

    function automatic bit usable(input int c, input int a);
        return (a < nregs_of(c)) && !((c == 0) && (a == 0));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[c][r]  = '0;
                m_pend[c][r] = 1'b0;
            end
        end
    endtask

    function automatic bit model_ready(input int c, input bit we, input int wa, input int ia);
        bit wl;
        wl = we && usable(c, wa);
        return !usable(c, ia) || !m_pend[c][ia] || (byp_of(c) && wl && (wa == ia));
    endfunction

    function automatic exp_t predict(input bit we, input int wa, input logic [31:0] wd,
                                     input int ia, input int r0, input int r1, input int r2);
        exp_t        e;
        int          ra[3];
        int          cnt;
        bit          wl;
        logic [31:0] d;
        bit          b;
        e  = '0;
        ra = '{r0, r1, r2};
        for (int c = 0; c < 2; c++) begin
            wl = we && usable(c, wa);
            for (int p = 0; p < ((c == 0) ? 3 : 2); p++) begin
                if (!usable(c, ra[p])) begin
                    d = '0; b = 1'b0;
                end else if (byp_of(c) && wl && (wa == ra[p])) begin
                    d = wd; b = 1'b0;
                end else begin
                    d = m_reg[c][ra[p]]; b = m_pend[c][ra[p]];
                end
                if (c == 0) begin e.rd_a[p] = d; e.bz_a[p] = b; end
                else        begin e.rd_b[p] = d; e.bz_b[p] = b; end
            end
            cnt = 0;
            for (int r = 0; r < 32; r++) cnt += int'(m_pend[c][r]);
            if (c == 0) begin e.rdy_a = model_ready(0, we, wa, ia); e.cnt_a = 8'(cnt); end
            else        begin e.rdy_b = model_ready(1, we, wa, ia); e.cnt_b = 8'(cnt); end
        end
        return e;
    endfunction

    task automatic model_step(input bit we, input int wa, input logic [31:0] wd,
                              input bit iv, input int ia, input bit fl);
        bit rdy;
        for (int c = 0; c < 2; c++) begin
            rdy = model_ready(c, we, wa, ia);
            if (we && usable(c, wa)) begin
                m_reg[c][wa]  = wd;
                m_pend[c][wa] = 1'b0;
            end
            if (fl) begin
                for (int r = 0; r < 32; r++) m_pend[c][r] = 1'b0;
            end else if (iv && rdy && usable(c, ia)) begin
                m_pend[c][ia] = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cycle(input bit we, input int wa, input logic [31:0] wd,
                         input bit iv, input int ia, input bit fl,
                         input int r0, input int r1, input int r2);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        regWrite   = we;
        writeAddr  = 5'(wa);
        writeData  = wd;
        issueValid = iv;
        issueAddr  = 5'(ia);
        flush      = fl;
        raddr_a    = {5'(r2), 5'(r1), 5'(r0)};
        raddr_b    = {5'(r1), 5'(r0)};
        sb_q.push_back(predict(we, wa, wd, ia, r0, r1, r2));
        model_step(we, wa, wd, iv, ia, fl);
        cyc++;
    endtask

    // Reset asserted mid-cycle; outputs must collapse immediately.
    task automatic reset_mid(input int r0, input int r1, input int r2);
        @(posedge clk);
        #1;
        regWrite   = 1'b0;
        issueValid = 1'b0;
        flush      = 1'b0;
        issueAddr  = 5'(r0);
        raddr_a    = {5'(r2), 5'(r1), 5'(r0)};
        raddr_b    = {5'(r1), 5'(r0)};
        #2;
        rst_n = 1'b0;
        model_reset();
        sb_q.push_back(predict(1'b0, 0, '0, r0, r0, r1, r2));
        cyc++;
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s[%0d] cycle=%0d got=%h expected=%h", name, idx, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            for (int p = 0; p < 3; p++) begin
                chk("readData_a", p, rdata_a[p*32 +: 32], mon_e.rd_a[p]);
                chk("readBusy_a", p, 32'(rbusy_a[p]), 32'(mon_e.bz_a[p]));
            end
            chk("issueReady_a", 0, 32'(ready_a), 32'(mon_e.rdy_a));
            chk("busyCount_a", 0, 32'(cnt_a), 32'(mon_e.cnt_a));
            for (int p = 0; p < 2; p++) begin
                chk("readData_b", p, rdata_b[p*32 +: 32], mon_e.rd_b[p]);
                chk("readBusy_b", p, 32'(rbusy_b[p]), 32'(mon_e.bz_b[p]));
            end
            chk("issueReady_b", 0, 32'(ready_b), 32'(mon_e.rdy_b));
            chk("busyCount_b", 0, 32'(cnt_b), 32'(mon_e.cnt_b));
        end
    end

    initial begin
        rst_n      = 1'b0;
        regWrite   = 1'b0;
        writeAddr  = '0;
        writeData  = '0;
        issueValid = 1'b0;
        issueAddr  = '0;
        flush      = 1'b0;
        raddr_a    = '0;
        raddr_b    = '0;
        model_reset();

        // reset state
        reset_mid(5, 0, 1);
        // write x5 then reset mid-cycle
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 1);
        cycle(0, 0, '0, 0, 0, 0, 5, 5, 5);
        reset_mid(5, 7, 0);
        // write with same-cycle read (bypass on A, old value on B)
        cycle(1, 7, 32'h12345678, 0, 0, 0, 7, 7, 0);
        cycle(0, 0, '0, 0, 0, 0, 7, 7, 0);
        // zero register
        cycle(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, '0, 0, 0, 0, 0, 0, 0);
        // scoreboard and WAW
        cycle(0, 0, '0, 1, 3, 0, 3, 3, 3);
        cycle(0, 0, '0, 1, 3, 0, 3, 0, 0);
        cycle(1, 3, 32'h000000A5, 0, 3, 0, 3, 0, 0);
        cycle(0, 0, '0, 0, 3, 0, 3, 0, 0);
        // simultaneous write+issue, then flush with issue
        cycle(1, 9, 32'h00000099, 1, 9, 0, 9, 0, 0);
        cycle(0, 0, '0, 0, 9, 0, 9, 0, 0);
        cycle(0, 0, '0, 1, 4, 0, 4, 9, 12);
        cycle(0, 0, '0, 1, 9, 0, 4, 9, 12);
        cycle(0, 0, '0, 1, 12, 0, 4, 9, 12);
        cycle(1, 4, 32'h44444444, 1, 20, 1, 20, 4, 12);
        cycle(0, 0, '0, 0, 20, 0, 20, 4, 12);
        // out-of-range address and concurrent independent ports
        cycle(1, 30, 32'h0000CAFE, 1, 30, 0, 30, 30, 30);
        cycle(0, 0, '0, 0, 30, 0, 30, 1, 2);
        cycle(1, 1, 32'h11111111, 0, 0, 0, 1, 2, 1);
        cycle(1, 2, 32'h22222222, 0, 0, 0, 1, 2, 1);
        cycle(0, 0, '0, 0, 0, 0, 1, 2, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                reset_mid(rnd_addr(), rnd_addr(), rnd_addr());
            end else begin
                cycle($urandom_range(0, 1) == 1, rnd_addr(), $urandom,
                      $urandom_range(0, 4) < 3, rnd_addr(),
                      $urandom_range(0, 24) == 0,
                      rnd_addr(), rnd_addr(), rnd_addr());
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the RISC-V core, and the successor to the fixed 32x32, 2-read-port register file.
- Configurable data width, register count and read-port count.
- Register 0 hardwired to zero (optional).
- Write-to-read bypass.
- Per-register pending (scoreboard) bits that track in-flight producers so decode can stall on RAW and WAW hazards.
- Sits between decode (read/issue) and writeback (write).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..64; need not be a power of 2)
NREAD, 2, number of independent read ports
AW, $clog2(NREGS), register address width (derived; do not override)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
readAddr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
readData  out  NREAD*XLEN  read data, combinational; port i at [i*XLEN +: XLEN]
readBusy  out  NREAD  pending flag of the addressed register, after bypass
regWrite  in  1  writeback enable
writeAddr  in  AW  writeback register
writeData  in  XLEN  writeback data
issueValid  in  1  decode requests to mark issueAddr pending
issueAddr  in  AW  destination of the issuing instruction
issueReady  out  1  combinational; 0 = WAW stall
flush  in  1  clear all pending bits (pipeline squash)
busyCount  out  $clog2(NREGS+1)  registered count of pending registers

Behaviour:
- Reset, asynchronous and immediate on rst_n low, including mid-operation:
  - all registers = 0, all pending bits = 0, busyCount = 0.
  - Combinational outputs follow: readData = 0, readBusy = 0.
- Write (posedge, regWrite=1):
  - reg[writeAddr] <= writeData; pending[writeAddr] <= 0.
  - Ignored if writeAddr >= NREGS, or if writeAddr = 0 and ZERO_REG = 1.
- Read (combinational, every port independent):
  - readData = reg[readAddr].
  - Address 0 with ZERO_REG=1, or address >= NREGS: readData = 0, readBusy = 0.
  - Bypass: if BYPASS=1, regWrite=1, writeAddr == readAddr and the write is legal, then readData = writeData and readBusy = 0.
  - If BYPASS=0: readData = old register value and readBusy = pending bit until the next edge.
- issueReady = !pending[issueAddr] OR (BYPASS=1 AND regWrite AND writeAddr == issueAddr).
  - Forced to 1 for address 0 (ZERO_REG=1) and for out-of-range addresses.
- Issue (posedge, issueValid AND issueReady AND NOT flush):
  - pending[issueAddr] <= 1.
  - Ignored for address 0 (ZERO_REG=1) and for out-of-range addresses.
- Same-edge events:
  - Write and issue to the same register: data written AND pending ends 1 (the new producer wins).
  - Write and issue to different registers: both take effect.
  - flush=1: all pending <= 0 and issue is ignored; a simultaneous write still updates data.
- busyCount:
  - Register updated as busyCount + set - clear, where set/clear count only actual 0->1 / 1->0 pending transitions.
  - On flush: 0.
  - Must always equal popcount(pending); never wraps; maximum NREGS-1 when ZERO_REG=1.
- Latency: read 0 cycles; write visible to a non-bypassed read 1 cycle after the edge; pending set visible the cycle after issue.
- No X propagation: unused address codes (>= NREGS) are fully decoded to the behaviour above.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEFAULT, NREGS_DEFAULT, ZERO_IDX = 0.
  - Function for busyCount width.
  - typedef of the address type from AW.
- Sub-module regfile_read_port:
  - One instance per read port via generate.
  - Contains the address mux, zero/out-of-range masking and bypass compare.
  - Outputs readData and readBusy for its port.
- Storage, pending vector, issue logic and busyCount stay in the top module.

Test Plan:
1. Reset then read: rst_n low mid-cycle after writing x5=0xDEADBEEF -> readData = 0 on all ports immediately, busyCount = 0, issueReady = 1.
2. Write/read and bypass: write x7=0x12345678 with readAddr0=7 in the same cycle -> readData0 = 0x12345678 in that cycle (BYPASS=1); with BYPASS=0 -> old value 0, then 0x12345678 next cycle.
3. Zero register: write x0=0xFFFFFFFF, issue x0 -> readData = 0, readBusy = 0, issueReady = 1, busyCount unchanged.
4. Scoreboard and WAW: issue x3, next cycle issue x3 -> issueReady = 0, readBusy = 1 on a port reading x3, busyCount = 1; writeback x3 = 0xA5 -> issueReady = 1 in that cycle, then pending clear and busyCount = 0.
5. Simultaneous write and issue to x9 -> reg x9 updated and pending x9 = 1 next cycle; issue x4, x9, x12, then flush together with issue x20 -> busyCount = 0 and x20 not pending.
6. Parameter sweep with NREGS=24, NREAD=3: accesses to address 30 -> reads 0, write ignored, issueReady = 1; three ports reading x1, x2, x1 concurrently return correct independent data.
